// File: rtl/level_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : level_monitor
//  Purpose  : Per-level attempt supervisor. It loads a level-dependent time
//             limit, counts it down once per second, and turns goal contact,
//             hazard contact and timer expiry into level_complete, respawn,
//             life-loss and game-over events.
//  Ports    : clk              - system clock
//             reset            - asynchronous, active-high reset
//             current_state    - game FSM state (00 RESET, 01 play,
//                                10 GAME_OVER, 11 WINNING_SCREEN)
//             current_level    - active level, 0..8
//             player_at_goal   - player overlaps goal zone (level-sensitive)
//             player_hit       - player overlaps a hazard (level-sensitive)
//             level_complete   - one-cycle pulse, level cleared
//             game_over_signal - held high once lives are exhausted
//             respawn          - one-cycle pulse, return player to start
//             lives            - remaining lives
//             time_left        - remaining seconds in the current attempt
//  Revision : 1.0 - initial release
// ============================================================================
module level_monitor #(
   parameter int TICKS_PER_SEC = 25000000,
   parameter int BASE_TIME     = 60,
   parameter int TIME_STEP     = 5,
   parameter int MIN_TIME      = 15,
   parameter int START_LIVES   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] current_state,
   input  logic [3:0] current_level,
   input  logic       player_at_goal,
   input  logic       player_hit,
   output logic       level_complete,
   output logic       game_over_signal,
   output logic       respawn,
   output logic [1:0] lives,
   output logic [6:0] time_left
);

   localparam int              PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]   TICK_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [1:0]      GS_RESET  = 2'b00;
   localparam logic [1:0]      GS_PLAY   = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_PLAY     = 3'd2,
      S_COOLDOWN = 3'd3,
      S_DONE     = 3'd4,
      S_OVER     = 3'd5
   } state_t;

   state_t          state;
   logic [PW-1:0]   prescaler;
   logic            clear_seen;   // one hit-free cycle already observed in cooldown
   logic            left_play;    // game FSM has left play since the level was cleared

   // Time limit at 16 bits so TIME_STEP*level can never wrap below MIN_TIME.
   logic [15:0] step_total;
   logic [6:0]  load_time;

   assign step_total = 16'(TIME_STEP) * {12'd0, current_level};
   assign load_time  = (16'(BASE_TIME) >= step_total + 16'(MIN_TIME))
                       ? 7'(16'(BASE_TIME) - step_total)
                       : 7'(MIN_TIME);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= S_IDLE;
         lives            <= 2'(START_LIVES);
         time_left        <= 7'd0;
         prescaler        <= '0;
         level_complete   <= 1'b0;
         game_over_signal <= 1'b0;
         respawn          <= 1'b0;
         clear_seen       <= 1'b0;
         left_play        <= 1'b0;
      end else begin
         level_complete <= 1'b0;
         respawn        <= 1'b0;

         if (current_state == GS_RESET) begin
            // Game reset overrides everything, including pulses in flight.
            state            <= S_IDLE;
            lives            <= 2'(START_LIVES);
            time_left        <= 7'd0;
            prescaler        <= '0;
            game_over_signal <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  lives <= 2'(START_LIVES);
                  if (current_state == GS_PLAY)
                     state <= S_LOAD;
               end

               S_LOAD: begin
                  time_left <= load_time;
                  respawn   <= 1'b1;
                  prescaler <= '0;
                  state     <= S_PLAY;
               end

               S_PLAY: begin
                  if (player_at_goal) begin
                     // Goal takes priority over a simultaneous hit.
                     level_complete <= 1'b1;
                     left_play      <= 1'b0;
                     state          <= S_DONE;
                  end else if (player_hit || time_left == 7'd0) begin
                     // Hit and expiry together are still a single event.
                     lives <= lives - 2'd1;
                     if (lives == 2'd1) begin
                        game_over_signal <= 1'b1;
                        state            <= S_OVER;
                     end else begin
                        clear_seen <= 1'b0;
                        state      <= S_COOLDOWN;
                     end
                  end else begin
                     if (prescaler == TICK_LAST) begin
                        prescaler <= '0;
                        if (time_left != 7'd0)
                           time_left <= time_left - 7'd1;
                     end else begin
                        prescaler <= prescaler + 1'b1;
                     end
                  end
               end

               S_COOLDOWN: begin
                  // Lingering contact restarts the wait instead of costing a life.
                  if (player_hit)
                     clear_seen <= 1'b0;
                  else if (clear_seen)
                     state <= S_LOAD;
                  else
                     clear_seen <= 1'b1;
               end

               S_DONE: begin
                  // Next level starts only on a fresh entry into play.
                  if (current_state != GS_PLAY)
                     left_play <= 1'b1;
                  else if (left_play)
                     state <= S_LOAD;
               end

               S_OVER: begin
                  game_over_signal <= 1'b1;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_level_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_level_monitor
//  Purpose  : Self-checking bench for level_monitor (TICKS_PER_SEC = 4).
//             A behavioural game model is stepped on every clock and reset
//             event and compared against all outputs; directed scenarios add
//             explicit checks, followed by a randomized play session.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_level_monitor;

   localparam int TPS   = 4;
   localparam int BASE  = 60;
   localparam int STEP  = 5;
   localparam int MINT  = 15;
   localparam int LIVES = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] current_state;
   logic [3:0] current_level;
   logic       player_at_goal;
   logic       player_hit;
   logic       level_complete;
   logic       game_over_signal;
   logic       respawn;
   logic [1:0] lives;
   logic [6:0] time_left;

   int n_vec  = 0;
   int n_miss = 0;

   level_monitor #(
      .TICKS_PER_SEC (TPS),
      .BASE_TIME     (BASE),
      .TIME_STEP     (STEP),
      .MIN_TIME      (MINT),
      .START_LIVES   (LIVES)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .current_state    (current_state),
      .current_level    (current_level),
      .player_at_goal   (player_at_goal),
      .player_hit       (player_hit),
      .level_complete   (level_complete),
      .game_over_signal (game_over_signal),
      .respawn          (respawn),
      .lives            (lives),
      .time_left        (time_left)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Phases named by what the player experiences.
   localparam int WAITING = 0, STARTING = 1, RUNNING = 2, RECOVERING = 3, CLEARED = 4, LOST = 5;

   int m_phase, m_lives, m_time, m_ticks, m_calm;
   bit m_away, m_lc, m_rsp, m_go;

   function automatic int time_limit(input int lvl);
      int t = BASE - STEP * lvl;
      return (t < MINT) ? MINT : t;
   endfunction

   task automatic model_reset();
      m_phase = WAITING; m_lives = LIVES; m_time = 0; m_ticks = 0;
      m_lc = 0; m_rsp = 0; m_go = 0;
   endtask

   task automatic model_step();
      m_lc  = 0;
      m_rsp = 0;
      if (current_state == 2'b00) begin
         m_phase = WAITING; m_lives = LIVES; m_time = 0; m_ticks = 0; m_go = 0;
         return;
      end
      case (m_phase)
         WAITING: begin
            m_lives = LIVES;
            if (current_state == 2'b01) m_phase = STARTING;
         end
         STARTING: begin
            m_time  = time_limit(int'(current_level));
            m_ticks = 0;
            m_rsp   = 1;
            m_phase = RUNNING;
         end
         RUNNING: begin
            if (player_at_goal) begin
               m_lc = 1; m_away = 0; m_phase = CLEARED;
            end else if (player_hit || m_time == 0) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) begin m_go = 1; m_phase = LOST; end
               else begin m_calm = 0; m_phase = RECOVERING; end
            end else begin
               m_ticks = (m_ticks + 1) % TPS;
               if (m_ticks == 0 && m_time > 0) m_time = m_time - 1;
            end
         end
         RECOVERING: begin
            m_calm = player_hit ? 0 : m_calm + 1;
            if (m_calm == 2) m_phase = STARTING;
         end
         CLEARED: begin
            if (current_state != 2'b01) m_away = 1;
            else if (m_away) m_phase = STARTING;
         end
         default: m_go = 1;
      endcase
   endtask

   // Model follows every clock and every reset assertion; outputs checked 1 time unit later.
   always @(posedge clk or posedge reset) begin
      #1;
      if (reset) model_reset();
      else       model_step();
      chk("lives",     32'(lives),            32'(m_lives));
      chk("time_left", 32'(time_left),        32'(m_time));
      chk("lvl_cmp",   32'(level_complete),   32'(m_lc));
      chk("respawn",   32'(respawn),          32'(m_rsp));
      chk("game_over", 32'(game_over_signal), 32'(m_go));
      chk("pulse_excl", 32'(level_complete & respawn), 32'd0);
   end

   // ---------------- directed helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_respawn(input string tag, input int budget);
      int k = 0;
      while (respawn !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(respawn), 32'd1);
   endtask

   task automatic wait_lives(input string tag, input logic [1:0] want, input int budget);
      int k = 0;
      while (lives !== want && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(lives), 32'(want));
   endtask

   task automatic new_game(input logic [3:0] lvl);
      current_state = 2'b00;
      cyc(1);
      current_level = lvl;
      current_state = 2'b01;
      wait_respawn("start_rsp", 8);
   endtask

   initial begin
      reset = 1'b1; current_state = 2'b00; current_level = 4'd0;
      player_at_goal = 1'b0; player_hit = 1'b0;
      cyc(3);
      chk("rst_lives", 32'(lives), 32'(LIVES));
      chk("rst_time",  32'(time_left), 32'd0);
      reset = 1'b0;
      cyc(2);

      // Level 0 start: respawn pulse, 60 s, one second per 4 clocks.
      current_state = 2'b01;
      wait_respawn("l0_rsp", 8);
      chk("l0_time60", 32'(time_left), 32'd60);
      cyc(4);
      chk("l0_time59", 32'(time_left), 32'd59);

      // Level 8 timeout: 20 s limit, expiry costs one life, reload to 20.
      new_game(4'd8);
      chk("l8_time20", 32'(time_left), 32'd20);
      wait_lives("l8_expire", 2'd2, 20 * TPS + 10);
      chk("l8_time0", 32'(time_left), 32'd0);
      wait_respawn("l8_rsp", 8);
      chk("l8_reload", 32'(time_left), 32'd20);

      // Held hit: exactly one life, reload two hit-free cycles later.
      cyc(2);
      player_hit = 1'b1;
      cyc(10);
      chk("hold_lives", 32'(lives), 32'd1);
      player_hit = 1'b0;
      cyc(2);
      chk("hold_norsp", 32'(respawn), 32'd0);
      cyc(1);
      chk("hold_rsp", 32'(respawn), 32'd1);

      // Three separated hits end the game.
      new_game(4'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(2);
         player_hit = 1'b1;
         cyc(1);
         player_hit = 1'b0;
         chk("hit_lives", 32'(lives), 32'(2 - i));
         if (i < 2) wait_respawn("hit_rsp", 8);
      end
      chk("over_set", 32'(game_over_signal), 32'd1);
      player_hit = 1'b1;
      cyc(5);
      player_hit = 1'b0;
      chk("over_held", 32'(game_over_signal), 32'd1);
      chk("over_lives", 32'(lives), 32'd0);
      current_state = 2'b00;
      cyc(1);
      chk("over_clr", 32'(game_over_signal), 32'd0);
      chk("over_lives3", 32'(lives), 32'd3);

      // Goal and hit together: goal wins, then DONE ignores contacts.
      new_game(4'd3);
      cyc(2);
      player_at_goal = 1'b1; player_hit = 1'b1;
      cyc(1);
      chk("goal_pulse", 32'(level_complete), 32'd1);
      chk("goal_lives", 32'(lives), 32'd3);
      cyc(3);
      chk("goal_once", 32'(level_complete), 32'd0);
      chk("done_lives", 32'(lives), 32'd3);
      player_at_goal = 1'b0; player_hit = 1'b0;
      cyc(2);
      chk("done_stay", 32'(respawn), 32'd0);
      current_state = 2'b11;
      cyc(1);
      current_state = 2'b01;
      wait_respawn("done_rsp", 6);
      chk("done_time", 32'(time_left), 32'd45);

      // Reset between edges during cooldown.
      cyc(2);
      player_hit = 1'b1;
      cyc(2);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_lives", 32'(lives), 32'(LIVES));
      chk("mid_time", 32'(time_left), 32'd0);
      chk("mid_rsp", 32'(respawn), 32'd0);
      chk("mid_go", 32'(game_over_signal), 32'd0);
      @(negedge clk);
      reset = 1'b0; player_hit = 1'b0;
      wait_respawn("mid_resume", 6);

      // Randomized session.
      for (int c = 0; c < 4000; c++) begin
         int r;
         @(negedge clk);
         if (reset) reset = 1'b0;
         r = int'($urandom_range(999, 0));
         if (r < 2)        reset = 1'b1;
         else if (r < 20)  current_state = 2'b00;
         else if (r < 50)  current_state = 2'($urandom_range(3, 2));
         else if (r < 400) current_state = 2'b01;
         if ($urandom_range(99, 0) < 3) current_level = 4'($urandom_range(8, 0));
         player_at_goal = ($urandom_range(99, 0) < 2);
         if ($urandom_range(99, 0) < 15) player_hit = ($urandom_range(99, 0) < 30);
      end
      @(negedge clk);
      reset = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
